// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU AXI-lite sampler.
//   - AXI response encoding
//   - FSM state codes (IDLE, AR, R, CLR, B, OUT)
//   - idx_bits(): index width helper with a floor of 1 bit
// The sample record {idx, data, last} depends on the top-level widths, so it
// is declared as a struct inside pmu_axil_sampler.
package pmu_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_AR   = 3'd1;
  localparam state_t ST_R    = 3'd2;
  localparam state_t ST_CLR  = 3'd3;
  localparam state_t ST_B    = 3'd4;
  localparam state_t ST_OUT  = 3'd5;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmu_axil_sampler_if.sv
// AXI-lite channel bundle between the sampler (master) and the shared
// counter register file port (slave).
//   AR: araddr, arvalid, arready      R: rdata, rresp, rvalid, rready
// With PMU_SAMPLER_CLEAR_ON_READ_EN defined, the bundle also carries
//   AW: awaddr, awvalid, awready      W: wdata, wstrb, wvalid, wready
//   B : bresp, bvalid, bready
interface pmu_axil_sampler_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
`else
  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );
  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
`endif

endinterface

// File: rtl/pmu_period_timer.sv
// Idle-period down counter for periodic sweeps.
//   clk, rst   : clock, async active-low reset (count resets to 0)
//   load       : load load_val (takes priority over decrement)
//   load_val   : reload value
//   dec_en     : decrement by one, saturating at 0
//   zero       : count == 0
module pmu_period_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec_en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt <= '0;
    else if (load)                  cnt <= load_val;
    else if (dec_en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pmu_axil_sampler.sv
// AXI-lite read master that sweeps the PMU counter file one counter per
// transaction and streams each value out as {idx, data, last}.
// Ports:
//   noc_clk, rst            : clock, async active-low reset
//   start_i                 : one-shot sweep request (level, sampled each cycle)
//   periodic_en_i, period_i : automatic sweeps, period_i idle cycles apart
//   busy_o                  : sweep in progress
//   err_o                   : sticky non-OKAY response since last accepted start
//   m_axi                   : AXI-lite master port (pmu_axil_sampler_if.master)
//   sample_*                : valid/ready sample stream
// Optional feature macro: PMU_SAMPLER_CLEAR_ON_READ_EN -- after each read the
// counter is written back to 0 (AW and W together, then B) before the sample
// is offered.
module pmu_axil_sampler
  import pmu_pkg::*;
#(
  parameter int                    NUM_COUNTERS = 23,
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    ADDR_STRIDE  = 8,
  parameter int                    IDX_WIDTH    = idx_bits(NUM_COUNTERS),
  parameter int                    PERIOD_WIDTH = 32
) (
  input  logic                    noc_clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    periodic_en_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic                    busy_o,
  output logic                    err_o,
  pmu_axil_sampler_if.master      m_axi,
  output logic                    sample_valid_o,
  input  logic                    sample_ready_i,
  output logic [IDX_WIDTH-1:0]    sample_idx_o,
  output logic [DATA_WIDTH-1:0]   sample_data_o,
  output logic                    sample_last_o
);

  typedef struct packed {
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } sample_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COUNTERS - 1);

  state_t                state;
  sample_t               smp;      // idx doubles as the sweep position
  logic                  pending;
  logic                  tmr_zero;
  logic                  trigger;
  logic                  out_hs;
  logic [ADDR_WIDTH-1:0] addr;

  // Modulo 2^ADDR_WIDTH by construction.
  assign addr    = BASE_ADDR + ADDR_WIDTH'(smp.idx) * ADDR_WIDTH'(ADDR_STRIDE);
  assign trigger = (state == ST_IDLE) && (start_i || pending || (periodic_en_i && tmr_zero));
  assign out_hs  = (state == ST_OUT) && sample_ready_i;

  assign m_axi.araddr  = addr;
  assign m_axi.arvalid = (state == ST_AR);
  assign m_axi.rready  = (state == ST_R);

  assign busy_o         = (state != ST_IDLE);
  assign sample_valid_o = (state == ST_OUT);
  assign sample_idx_o   = smp.idx;
  assign sample_data_o  = smp.data;
  assign sample_last_o  = smp.last;

`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
  // AW and W go up together on CLR entry; each drops on its own handshake.
  logic aw_done, w_done, clr_done;

  assign m_axi.awaddr  = addr;
  assign m_axi.awvalid = (state == ST_CLR) && !aw_done;
  assign m_axi.wdata   = '0;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = (state == ST_CLR) && !w_done;
  assign m_axi.bready  = (state == ST_B);
  assign clr_done      = (aw_done || m_axi.awready) && (w_done || m_axi.wready);

  always_ff @(posedge noc_clk or negedge rst) begin
    if (!rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != ST_CLR) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (m_axi.awready) aw_done <= 1'b1;
      if (m_axi.wready)  w_done  <= 1'b1;
    end
  end
`endif

  always_ff @(posedge noc_clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      smp     <= '0;
      pending <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      // One-deep request memory; extra starts while busy collapse into it.
      if (start_i && state != ST_IDLE) pending <= 1'b1;

      case (state)
        ST_IDLE: if (trigger) begin
          state   <= ST_AR;
          pending <= 1'b0;
          if (start_i || pending) err_o <= 1'b0;
        end
        ST_AR: if (m_axi.arready) state <= ST_R;
        ST_R: if (m_axi.rvalid) begin
          smp.data <= (m_axi.rresp == AXI_RESP_OKAY) ? m_axi.rdata : '0;
          smp.last <= (smp.idx == LAST_IDX);
          if (m_axi.rresp != AXI_RESP_OKAY) err_o <= 1'b1;
`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
          state <= ST_CLR;
`else
          state <= ST_OUT;
`endif
        end
`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
        ST_CLR: if (clr_done) state <= ST_B;
        ST_B: if (m_axi.bvalid) begin
          if (m_axi.bresp != AXI_RESP_OKAY) err_o <= 1'b1;
          state <= ST_OUT;
        end
`endif
        ST_OUT: if (sample_ready_i) begin
          smp.last <= 1'b0;
          if (smp.last) begin
            state   <= ST_IDLE;
            smp.idx <= '0;
          end else begin
            smp.idx <= smp.idx + 1'b1;
            state   <= ST_AR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Loaded on the final handshake; counting down in IDLE gives the next
  // periodic arvalid exactly period_i+1 cycles after that handshake.
  pmu_period_timer #(.WIDTH(PERIOD_WIDTH)) u_timer (
    .clk      (noc_clk),
    .rst      (rst),
    .load     (out_hs && smp.last),
    .load_val (period_i),
    .dec_en   (state == ST_IDLE),
    .zero     (tmr_zero)
  );

endmodule

// File: tb/tb_pmu_axil_sampler.sv
module tb_pmu_axil_sampler;
  localparam int N = 4, AW = 64, DW = 64, STRIDE = 8, PW = 32, IW = 2;
  localparam logic [AW-1:0] BASE = '0;

  logic          noc_clk = 1'b0, rst = 1'b0, start_i = 1'b0, periodic_en_i = 1'b0;
  logic [PW-1:0] period_i = '0;
  logic          busy_o, err_o, sample_valid_o, sample_last_o;
  logic          sample_ready_i = 1'b0;
  logic [IW-1:0] sample_idx_o;
  logic [DW-1:0] sample_data_o;

  pmu_axil_sampler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  pmu_axil_sampler #(
    .NUM_COUNTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
    .ADDR_STRIDE(STRIDE), .IDX_WIDTH(IW), .PERIOD_WIDTH(PW)
  ) dut (
    .noc_clk(noc_clk), .rst(rst), .start_i(start_i), .periodic_en_i(periodic_en_i),
    .period_i(period_i), .busy_o(busy_o), .err_o(err_o), .m_axi(axi),
    .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
    .sample_idx_o(sample_idx_o), .sample_data_o(sample_data_o), .sample_last_o(sample_last_o)
  );

  always #5 noc_clk = ~noc_clk;

  int cyc = 0;
  always @(posedge noc_clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  typedef struct { logic [IW-1:0] idx; logic [DW-1:0] data; logic last; } smp_t;
  smp_t          q_smp[$];
  logic [AW-1:0] q_ar[$];
  int            q_start[$], q_end[$];
`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
  logic [AW-1:0]   q_wa[$];
  logic [DW-1:0]   q_wd[$];
  logic [DW/8-1:0] q_ws[$];
`endif

  int slv_rate = 100, cons_rate = 100, err_idx = -1, hold_idx = -1, hold_left = 0;
  bit ar_block = 0;

  // Reference model: counter i lives at BASE + i*STRIDE and the slave returns
  // address*2; an errored read is delivered as 0.
  function automatic logic [DW-1:0] model_data(input int i, input int erri);
    logic [AW-1:0] a;
    a = BASE + AW'(i * STRIDE);
    return (i == erri) ? '0 : DW'(a << 1);
  endfunction

  // Environment: AXI slave, sample consumer and monitor, all at negedge.
  // Handshakes are decided here, so they are logged before the posedge.
  initial begin : env
    bit ar_hs, r_hs, have_req, prev_arv;
    logic [AW-1:0] req_addr;
    int rdly;
    smp_t s;
`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
    bit aw_hs, w_hs, b_hs, got_aw, got_w;
    logic [AW-1:0] wa; logic [DW-1:0] wd; logic [DW/8-1:0] ws;
    aw_hs = 0; w_hs = 0; b_hs = 0; got_aw = 0; got_w = 0; wa = '0; wd = '0; ws = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
`endif
    ar_hs = 0; r_hs = 0; have_req = 0; prev_arv = 0; req_addr = '0; rdly = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00;
    forever begin
      @(negedge noc_clk);
      if (!rst) begin
        ar_hs = 0; r_hs = 0; have_req = 0; prev_arv = 0;
        axi.arready = 0; axi.rvalid = 0; sample_ready_i = 0;
`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
        aw_hs = 0; w_hs = 0; b_hs = 0; got_aw = 0; got_w = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
`endif
        continue;
      end
      if (r_hs) begin axi.rvalid = 0; have_req = 0; end
      if (ar_hs) have_req = 1;
      axi.arready = !have_req && !ar_block && ($urandom_range(0, 99) < slv_rate);
      if (have_req && !axi.rvalid) begin
        if (rdly > 0) rdly--;
        else begin
          axi.rvalid = 1;
          axi.rdata  = DW'(req_addr << 1);
          axi.rresp  = (err_idx >= 0 && req_addr == BASE + AW'(err_idx * STRIDE)) ? 2'b10 : 2'b00;
        end
      end
`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
      if (b_hs) begin axi.bvalid = 0; got_aw = 0; got_w = 0; end
      if (aw_hs) got_aw = 1;
      if (w_hs) got_w = 1;
      axi.awready = !got_aw && ($urandom_range(0, 99) < slv_rate);
      axi.wready  = !got_w && ($urandom_range(0, 99) < slv_rate);
      if (got_aw && got_w && !axi.bvalid) begin
        axi.bvalid = 1; axi.bresp = 2'b00;
        q_wa.push_back(wa); q_wd.push_back(wd); q_ws.push_back(ws);
      end
      aw_hs = axi.awvalid && axi.awready; if (aw_hs) wa = axi.awaddr;
      w_hs  = axi.wvalid && axi.wready;   if (w_hs) begin wd = axi.wdata; ws = axi.wstrb; end
      b_hs  = axi.bvalid && axi.bready;
`endif
      if (sample_valid_o && hold_left > 0 && int'(sample_idx_o) == hold_idx) begin
        sample_ready_i = 0; hold_left--;
      end else sample_ready_i = ($urandom_range(0, 99) < cons_rate);
      if (axi.arvalid && !prev_arv && axi.araddr == BASE) q_start.push_back(cyc);
      prev_arv = axi.arvalid;
      ar_hs = axi.arvalid && axi.arready;
      if (ar_hs) begin
        req_addr = axi.araddr; q_ar.push_back(axi.araddr);
        rdly = (slv_rate < 100) ? $urandom_range(0, 2) : 0;
      end
      r_hs = axi.rvalid && axi.rready;
      if (sample_valid_o && sample_ready_i) begin
        s.idx = sample_idx_o; s.data = sample_data_o; s.last = sample_last_o;
        q_smp.push_back(s);
        if (sample_last_o) q_end.push_back(cyc + 1);
      end
    end
  end

  task automatic tick();
    @(negedge noc_clk); #1;
  endtask

  task automatic clear_logs();
    q_smp.delete(); q_ar.delete(); q_start.delete(); q_end.delete();
`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
    q_wa.delete(); q_wd.delete(); q_ws.delete();
`endif
  endtask

  task automatic pulse_start();
    start_i = 1; tick(); start_i = 0;
  endtask

  task automatic wait_ends(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (q_end.size() < n && t < budget) begin tick(); t++; end
    n_cmp++;
    if (q_end.size() < n) begin
      n_err++;
      $display("FAIL %s timeout: %0d sweep ends seen, need %0d", tag, q_end.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({busy_o, axi.arvalid, axi.rready, sample_valid_o} !== 4'b0) begin
      n_err++; $display("FAIL reset_held outputs=%b expected 0000", {busy_o, axi.arvalid, axi.rready, sample_valid_o});
    end
    rst = 1; tick();
    n_cmp++;
    if ({busy_o, err_o, axi.arvalid, axi.rready, sample_valid_o} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl outputs=%b expected 00000", {busy_o, err_o, axi.arvalid, axi.rready, sample_valid_o});
    end
    n_cmp++;
    if (axi.araddr !== BASE) begin n_err++; $display("FAIL reset_araddr got %h expected %h", axi.araddr, BASE); end
    n_cmp++;
    if ({sample_idx_o, sample_data_o} !== '0) begin
      n_err++; $display("FAIL reset_sample idx=%0d data=%h expected 0/0", sample_idx_o, sample_data_o);
    end
  endtask

  task automatic test_sweep(input int srate, input int crate);
    smp_t s;
    slv_rate = srate; cons_rate = crate; clear_logs();
    pulse_start();
    wait_ends(1, 500, "sweep");
    tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL sweep_busy_drop busy=%b expected 0", busy_o); end
    n_cmp++;
    if (err_o !== 1'b0) begin n_err++; $display("FAIL sweep_err err=%b expected 0", err_o); end
    n_cmp++;
    if (q_smp.size() != N) begin n_err++; $display("FAIL sweep_count got %0d expected %0d", q_smp.size(), N); end
    for (int i = 0; i < N && i < q_smp.size(); i++) begin
      s = q_smp[i];
      n_cmp++;
      if ({s.idx, s.data, s.last} !== {IW'(i), model_data(i, -1), (i == N - 1)}) begin
        n_err++;
        $display("FAIL sweep_sample%0d got idx=%0d data=%h last=%b expected idx=%0d data=%h last=%b",
                 i, s.idx, s.data, s.last, i, model_data(i, -1), (i == N - 1));
      end
      n_cmp++;
      if (q_ar[i] !== BASE + AW'(i * STRIDE)) begin
        n_err++; $display("FAIL sweep_araddr%0d got %h expected %h", i, q_ar[i], BASE + AW'(i * STRIDE));
      end
    end
`ifdef PMU_SAMPLER_CLEAR_ON_READ_EN
    n_cmp++;
    if (q_wa.size() != N) begin n_err++; $display("FAIL clr_count got %0d expected %0d", q_wa.size(), N); end
    for (int i = 0; i < N && i < q_wa.size(); i++) begin
      n_cmp++;
      if ({q_wa[i], q_wd[i], q_ws[i]} !== {BASE + AW'(i * STRIDE), DW'(0), {(DW/8){1'b1}}}) begin
        n_err++; $display("FAIL clr_write%0d got addr=%h data=%h strb=%h", i, q_wa[i], q_wd[i], q_ws[i]);
      end
    end
`endif
  endtask

  task automatic test_backpressure();
    int t;
    slv_rate = 100; cons_rate = 100; clear_logs();
    hold_idx = 1; hold_left = 5;
    pulse_start();
    t = 0;
    while (!(sample_valid_o && sample_idx_o == 1) && t < 200) begin tick(); t++; end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({sample_valid_o, sample_idx_o, sample_data_o, axi.arvalid} !== {1'b1, IW'(1), model_data(1, -1), 1'b0}) begin
        n_err++;
        $display("FAIL hold_cycle%0d valid=%b idx=%0d data=%h arvalid=%b expected 1/1/%h/0",
                 k, sample_valid_o, sample_idx_o, sample_data_o, axi.arvalid, model_data(1, -1));
      end
      if (k < 4) tick();
    end
    wait_ends(1, 500, "hold");
    n_cmp++;
    if (q_smp.size() != N) begin n_err++; $display("FAIL hold_count got %0d expected %0d", q_smp.size(), N); end
    hold_idx = -1; hold_left = 0;
    tick();
  endtask

  task automatic test_error();
    smp_t s;
    slv_rate = 70; cons_rate = 70; err_idx = 2; clear_logs();
    pulse_start();
    wait_ends(1, 800, "error");
    tick();
    for (int i = 0; i < N && i < q_smp.size(); i++) begin
      s = q_smp[i];
      n_cmp++;
      if ({s.idx, s.data} !== {IW'(i), model_data(i, 2)}) begin
        n_err++; $display("FAIL err_sample%0d got idx=%0d data=%h expected %h", i, s.idx, s.data, model_data(i, 2));
      end
    end
    repeat (5) tick();
    n_cmp++;
    if (err_o !== 1'b1) begin n_err++; $display("FAIL err_sticky err=%b expected 1", err_o); end
    err_idx = -1; clear_logs();
    pulse_start();
    n_cmp++;
    if ({err_o, busy_o} !== 2'b01) begin n_err++; $display("FAIL err_clear err/busy=%b expected 01", {err_o, busy_o}); end
    wait_ends(1, 800, "error_clear");
    tick();
    n_cmp++;
    if (err_o !== 1'b0) begin n_err++; $display("FAIL err_clean_sweep err=%b expected 0", err_o); end
  endtask

  task automatic test_back_to_back();
    smp_t s;
    slv_rate = 60; cons_rate = 60; clear_logs();
    pulse_start();
    repeat (2) tick();
    pulse_start();
    repeat (2) tick();
    pulse_start();
    wait_ends(2, 1500, "pending");
    repeat (40) tick();
    n_cmp++;
    if ({q_start.size(), q_end.size(), q_smp.size()} !== {32'd2, 32'd2, 32'(2 * N)}) begin
      n_err++; $display("FAIL pending_sweeps starts=%0d ends=%0d samples=%0d expected 2/2/%0d",
                        q_start.size(), q_end.size(), q_smp.size(), 2 * N);
    end
    for (int i = 0; i < q_smp.size(); i++) begin
      s = q_smp[i];
      n_cmp++;
      if ({s.idx, s.data} !== {IW'(i % N), model_data(i % N, -1)}) begin
        n_err++; $display("FAIL pending_sample%0d got idx=%0d data=%h", i, s.idx, s.data);
      end
    end
  endtask

  task automatic test_periodic();
    int t, p;
    for (int run = 0; run < 2; run++) begin
      p = (run == 0) ? 10 : $urandom_range(0, 3);
      slv_rate = 80; cons_rate = 80; clear_logs();
      period_i = PW'(p); periodic_en_i = 1;
      t = 0;
      while (q_start.size() < 4 && t < 3000) begin tick(); t++; end
      periodic_en_i = 0;
      wait_ends(4, 1000, "periodic");
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (q_start[k+1] - q_end[k] != p + 1) begin
          n_err++; $display("FAIL periodic_gap p=%0d sweep%0d got %0d cycles expected %0d",
                            p, k, q_start[k+1] - q_end[k], p + 1);
        end
      end
      repeat (40) tick();
      n_cmp++;
      if ({q_start.size(), q_smp.size()} !== {32'd4, 32'(4 * N)}) begin
        n_err++; $display("FAIL periodic_stop starts=%0d samples=%0d expected 4/%0d", q_start.size(), q_smp.size(), 4 * N);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int t;
    slv_rate = 100; cons_rate = 100; ar_block = 1;
    pulse_start();
    t = 0;
    while (!axi.arvalid && t < 20) begin tick(); t++; end
    rst = 0; #1;
    n_cmp++;
    if ({axi.arvalid, busy_o, sample_valid_o, axi.rready} !== 4'b0) begin
      n_err++; $display("FAIL rst_abort arvalid/busy/valid/rready=%b expected 0000",
                        {axi.arvalid, busy_o, sample_valid_o, axi.rready});
    end
    repeat (2) tick();
    rst = 1; ar_block = 0; tick();
    test_sweep(100, 100);
  endtask

  initial begin : main
    test_reset();
    test_sweep(100, 100);
    test_sweep(50, 60);
    test_backpressure();
    test_error();
    test_back_to_back();
    test_periodic();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
